// File: rtl/core_pkg.sv
// Shared definitions for the multicycle core: opcode map, FSM states and
// opcode-class helpers used by decode, operand select and writeback.
package core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HLT  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_RSV  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_SUBI = 4'hB;
  localparam logic [3:0] OP_ANDI = 4'hC;
  localparam logic [3:0] OP_ORI  = 4'hD;
  localparam logic [3:0] OP_XORI = 4'hE;
  localparam logic [3:0] OP_CMPI = 4'hF;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_READ, S_EXEC, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_fn_t;

  function automatic logic is_alu_rr(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_CMP, OP_OR, OP_XOR};
  endfunction

  function automatic logic is_alu_imm(input logic [3:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_CMPI};
  endfunction

  // Compares only update flags; LDI is the single non-ALU register writer.
  function automatic logic writes_rd(input logic [3:0] op);
    return (op == OP_LDI) ||
           ((is_alu_rr(op) || is_alu_imm(op)) && (op != OP_CMP) && (op != OP_CMPI));
  endfunction

  function automatic alu_fn_t alu_fn(input logic [3:0] op);
    case (op)
      OP_SUB, OP_SUBI, OP_CMP, OP_CMPI: return ALU_SUB;
      OP_AND, OP_ANDI:                  return ALU_AND;
      OP_OR, OP_ORI:                    return ALU_OR;
      OP_XOR, OP_XORI:                  return ALU_XOR;
      default:                          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/core_regfile.sv
// NREG x DATA_W register file: two combinational read ports, one synchronous
// write port, cleared by the asynchronous active-low reset.
module core_regfile #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle sequenced core: req/ack instruction fetch, register file,
// inline flag-producing ALU, retire/writeback observation port.
//
//   state    | meaning
//   S_FETCH  | request imem[pc], wait for ack, latch IR
//   S_DECODE | classify opcode; NOP/reserved retire here
//   S_READ   | latch operands A=R[rd], B=R[rs] or sext(imm)
//   S_EXEC   | ALU result and Z/N/C latched
//   S_WB     | register write (unless compare), pc+1, retire
//   S_HALT   | terminal until reset
module multicycle_core
  import core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int PC_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_ack,
  input  logic [3+2*REG_AW:0]   imem_data,
  output logic [PC_W-1:0]       pc,
  output logic                  halted,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  retire,
  output logic                  wb_en,
  output logic [REG_AW-1:0]     wb_addr,
  output logic [DATA_W-1:0]     wb_data
);

  localparam int INSTR_W = 4 + 2 * REG_AW;

  state_t               state, state_nx;
  logic [INSTR_W-1:0]   ir;
  logic                 fetch_arm;
  logic                 pc_inc;
  logic [3:0]           op;
  logic [REG_AW-1:0]    rd_idx, rs_idx;
  logic [DATA_W-1:0]    imm_sx, rf_rd0, rf_rd1;
  logic [DATA_W-1:0]    a_q, b_q, res_q, alu_res;
  logic [DATA_W:0]      alu_wide;
  logic                 alu_c;

  assign op     = ir[INSTR_W-1 -: 4];
  assign rd_idx = ir[2*REG_AW-1 -: REG_AW];
  assign rs_idx = ir[REG_AW-1:0];
  assign imm_sx = {{(DATA_W-REG_AW){rs_idx[REG_AW-1]}}, rs_idx};

  // fetch_arm keeps the first request one cycle clear of reset release
  assign imem_req  = (state == S_FETCH) && fetch_arm;
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);
  assign wb_addr   = rd_idx;
  assign wb_data   = (op == OP_LDI) ? imm_sx : res_q;

  core_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra0 (rd_idx),
    .rd0 (rf_rd0),
    .ra1 (rs_idx),
    .rd1 (rf_rd1),
    .we  (wb_en),
    .wa  (rd_idx),
    .wd  (wb_data)
  );

  // SUB carry is the inverted borrow so that C=1 means rd >= operand
  always_comb begin
    alu_wide = '0;
    alu_c    = 1'b0;
    case (alu_fn(op))
      ALU_ADD: begin
        alu_wide = {1'b0, a_q} + {1'b0, b_q};
        alu_c    = alu_wide[DATA_W];
      end
      ALU_SUB: begin
        alu_wide = {1'b0, a_q} - {1'b0, b_q};
        alu_c    = ~alu_wide[DATA_W];
      end
      ALU_AND: alu_wide = {1'b0, a_q & b_q};
      ALU_OR:  alu_wide = {1'b0, a_q | b_q};
      ALU_XOR: alu_wide = {1'b0, a_q ^ b_q};
      default: alu_wide = '0;
    endcase
  end

  assign alu_res = alu_wide[DATA_W-1:0];

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    wb_en    = 1'b0;
    pc_inc   = 1'b0;
    case (state)
      S_FETCH:  if (imem_req && imem_ack) state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_NOP, OP_RSV: begin
            state_nx = S_FETCH;
            retire   = en;
            pc_inc   = 1'b1;
          end
          OP_HLT:  state_nx = S_HALT;
          OP_LDI:  state_nx = S_WB;
          default: state_nx = S_READ;
        endcase
      end
      S_READ:   state_nx = S_EXEC;
      S_EXEC:   state_nx = S_WB;
      S_WB: begin
        state_nx = S_FETCH;
        retire   = en;
        wb_en    = en && writes_rd(op);
        pc_inc   = 1'b1;
      end
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      fetch_arm <= 1'b0;
      pc        <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
    end else begin
      fetch_arm <= 1'b1;
      if (en) begin
        state <= state_nx;
        if (pc_inc) pc <= pc + PC_W'(1);
        if (imem_req && imem_ack) ir <= imem_data;
        if (state == S_READ) begin
          a_q <= rf_rd0;
          b_q <= is_alu_imm(op) ? imm_sx : rf_rd1;
        end
        if (state == S_EXEC) begin
          res_q  <= alu_res;
          flag_z <= (alu_res == '0);
          flag_n <= alu_res[DATA_W-1];
          flag_c <= alu_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core (DATA_W=8, REG_AW=2, PC_W=4): directed scenarios
// plus a random program checked against an instruction-level model.
module tb_multicycle_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [3:0] pc;
  logic       halted, flag_z, flag_n, flag_c, retire, wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] imem [16];
  int  ack_wait = 0;
  int  wcnt = 0;
  bit  manual = 0;

  int m_reg [4];
  bit m_z, m_n, m_c;
  int m_pc;

  always #5 clk = ~clk;

  multicycle_core #(.DATA_W(8), .REG_AW(2), .PC_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .pc        (pc),
    .halted    (halted),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .retire    (retire),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  // Instruction memory: acks after ack_wait request cycles, holds ack until taken.
  initial begin
    imem_ack  = 1'b0;
    imem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!manual) begin
        if (!rst || !imem_req) begin
          wcnt = 0;
          imem_ack = 1'b0;
        end else if (wcnt >= ack_wait) begin
          imem_ack  = 1'b1;
          imem_data = imem[imem_addr];
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Instruction-level reference: updates model state, returns latency and writeback.
  function automatic void model_step(input logic [7:0] ins, output int lat,
                                     output bit we, output int wa, output int wd);
    int op, rd, rs, imm, a, b, s, r;
    op = int'(ins[7:4]);
    rd = int'(ins[3:2]);
    rs = int'(ins[1:0]);
    imm = (rs >= 2) ? rs - 4 : rs;
    we = 0; wa = rd; wd = 0; lat = 2;
    a = m_reg[rd];
    b = (op inside {4, 5, 6, 7, 8, 10}) ? m_reg[rs] : (imm & 255);
    if (op == 2) begin
      lat = 3; we = 1; wd = imm & 255;
    end else if (op >= 4) begin
      lat = 5;
      if (op == 4 || op == 9) s = a + b;
      else if (op inside {5, 7, 11, 15}) s = a - b;
      else if (op == 6 || op == 12) s = a & b;
      else if (op == 8 || op == 13) s = a | b;
      else s = a ^ b;
      r = s & 255;
      m_z = (r == 0);
      m_n = (r >= 128);
      if (op == 4 || op == 9) m_c = (s > 255);
      else if (op inside {5, 7, 11, 15}) m_c = (a >= b);
      else m_c = 0;
      if (op != 7 && op != 15) begin we = 1; wd = r; end
    end
    if (we) m_reg[rd] = wd;
    m_pc = (m_pc + 1) % 16;
  endfunction

  task automatic wait_retire(input int max, output int n, output bit we,
                             output int wa, output int wd);
    n = 0; we = 0; wa = 0; wd = 0;
    do begin
      @(negedge clk);
      n++;
      if (wb_en) begin we = 1; wa = int'(wb_addr); wd = int'(wb_data); end
    end while (!retire && n < max);
    if (!retire) begin
      total++; bad++;
      $display("FAIL retire_timeout: no retire within %0d cycles", max);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int n, wa, wd; bit we;
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    ack_wait = 0; en = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({imem_req, pc, halted, retire, wb_en, flag_z, flag_n, flag_c} !== 10'd0) begin
      bad++; $display("FAIL reset_state: req=%b pc=%0d halted=%b retire=%b wb_en=%b", imem_req, pc, halted, retire, wb_en);
    end
    rst = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL req_at_release: got %b want 0", imem_req); end
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 4'd0) begin
      bad++; $display("FAIL first_fetch: req=%b addr=%0d want req=1 addr=0", imem_req, imem_addr);
    end
    wait_retire(10, n, we, wa, wd);
    total++;
    if (n !== 1) begin bad++; $display("FAIL nop_first_retire: got %0d want 1", n); end
    wait_retire(10, n, we, wa, wd);
    total++;
    if (n !== 2 || we !== 0) begin bad++; $display("FAIL nop_latency: got n=%0d we=%b want 2,0", n, we); end
    ack_wait = 100;
    repeat (3) @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || pc !== 4'd2) begin bad++; $display("FAIL stalled_fetch: req=%b pc=%0d want 1,2", imem_req, pc); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || pc !== 4'd0 || halted !== 1'b0) begin
      bad++; $display("FAIL async_reset: req=%b pc=%0d halted=%b want 0,0,0", imem_req, pc, halted);
    end
    ack_wait = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_program();
    int n, wa, wd; bit we;
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    imem[0] = 8'h25; imem[1] = 8'h45; imem[2] = 8'h2A; imem[3] = 8'h49; imem[4] = 8'h75;
    do_reset();
    wait_retire(10, n, we, wa, wd);
    total++;
    if (n !== 3 || we !== 1 || wa !== 1 || wd !== 8'h01) begin
      bad++; $display("FAIL ldi_r1: n=%0d we=%b wa=%0d wd=%h want 3,1,1,01", n, we, wa, wd);
    end
    wait_retire(10, n, we, wa, wd);
    total++;
    if (n !== 5 || we !== 1 || wa !== 1 || wd !== 8'h02) begin
      bad++; $display("FAIL add_r1: n=%0d we=%b wa=%0d wd=%h want 5,1,1,02", n, we, wa, wd);
    end
    total++;
    if ({flag_z, flag_n, flag_c} !== 3'b000) begin bad++; $display("FAIL add_r1_flags: znc=%b%b%b want 000", flag_z, flag_n, flag_c); end
    wait_retire(10, n, we, wa, wd);
    total++;
    if (n !== 3 || wa !== 2 || wd !== 8'hFE) begin bad++; $display("FAIL ldi_r2: n=%0d wa=%0d wd=%h want 3,2,fe", n, wa, wd); end
    wait_retire(10, n, we, wa, wd);
    total++;
    if (we !== 1 || wa !== 2 || wd !== 8'h00 || {flag_z, flag_n, flag_c} !== 3'b101) begin
      bad++; $display("FAIL add_wrap: we=%b wa=%0d wd=%h znc=%b%b%b want 1,2,00,101", we, wa, wd, flag_z, flag_n, flag_c);
    end
    wait_retire(10, n, we, wa, wd);
    total++;
    if (n !== 5 || we !== 0 || pc !== 4'd4 || {flag_z, flag_n, flag_c} !== 3'b101) begin
      bad++; $display("FAIL cmp: n=%0d we=%b pc=%0d znc=%b%b%b want 5,0,4,101", n, we, pc, flag_z, flag_n, flag_c);
    end
  endtask

  task automatic test_wait_en();
    int n, wa, wd; bit we;
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    imem[0] = 8'h25; imem[1] = 8'h45; imem[2] = 8'h45;
    ack_wait = 0;
    do_reset();
    wait_retire(10, n, we, wa, wd);
    ack_wait = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 4'd1) begin
        bad++; $display("FAIL wait_hold: cycle %0d req=%b addr=%0d want 1,1", k, imem_req, imem_addr);
      end
    end
    wait_retire(20, n, we, wa, wd);
    total++;
    if (n + 3 !== 8 || wd !== 8'h02) begin bad++; $display("FAIL wait_latency: cycles=%0d wd=%h want 8,02", n + 3, wd); end
    ack_wait = 0;
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    total++;
    if (retire !== 1'b0 || wb_en !== 1'b0) begin bad++; $display("FAIL en_freeze: retire=%b wb_en=%b want 0,0", retire, wb_en); end
    en = 1'b1;
    wait_retire(10, n, we, wa, wd);
    total++;
    if (n + 5 !== 6 || wd !== 8'h04) begin bad++; $display("FAIL en_stall: cycles=%0d wd=%h want 6,04", n + 5, wd); end
  endtask

  task automatic test_halt();
    int n, wa, wd; bit we;
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    imem[5] = 8'h10;
    do_reset();
    for (int k = 0; k < 5; k++) wait_retire(10, n, we, wa, wd);
    n = 0;
    do begin @(negedge clk); n++; end while (!halted && n < 10);
    total++;
    if (halted !== 1'b1 || n !== 3 || pc !== 4'd5) begin
      bad++; $display("FAIL halt_entry: halted=%b cycles=%0d pc=%0d want 1,3,5", halted, n, pc);
    end
    manual = 1;
    for (int k = 0; k < 20; k++) begin
      en = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      imem_data = 8'($urandom);
      @(negedge clk);
      total++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 4'd5 || retire !== 1'b0 || wb_en !== 1'b0) begin
        bad++; $display("FAIL halt_hold: cycle %0d req=%b halted=%b pc=%0d retire=%b", k, imem_req, halted, pc, retire);
      end
    end
    manual = 0;
    imem_ack = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_pc_wrap();
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 4'(i % 16)) begin
        bad++; $display("FAIL pc_wrap: step %0d req=%b addr=%0d want 1,%0d", i, imem_req, imem_addr, i % 16);
      end
      @(negedge clk);
      total++;
      if (retire !== 1'b1) begin bad++; $display("FAIL nop_retire: step %0d retire=%b want 1", i, retire); end
    end
  endtask

  task automatic test_reset_mid_exec();
    int n, wa, wd; bit we;
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    imem[0] = 8'h27; imem[1] = 8'h45; imem[2] = 8'h45;
    do_reset();
    wait_retire(10, n, we, wa, wd);
    wait_retire(10, n, we, wa, wd);
    total++;
    if (wd !== 8'hFE || {flag_z, flag_n, flag_c} !== 3'b011) begin
      bad++; $display("FAIL pre_reset_add: wd=%h znc=%b%b%b want fe,011", wd, flag_z, flag_n, flag_c);
    end
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (wb_en !== 1'b0 || retire !== 1'b0 || pc !== 4'd0 || {flag_z, flag_n, flag_c} !== 3'b000) begin
      bad++; $display("FAIL reset_in_exec: wb_en=%b retire=%b pc=%0d znc=%b%b%b want 0,0,0,000", wb_en, retire, pc, flag_z, flag_n, flag_c);
    end
    imem[0] = 8'h45;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_retire(10, n, we, wa, wd);
    total++;
    if (n !== 5 || we !== 1 || wa !== 1 || wd !== 8'h00 || flag_z !== 1'b1) begin
      bad++; $display("FAIL regs_cleared: n=%0d we=%b wa=%0d wd=%h z=%b want 5,1,1,00,1", n, we, wa, wd, flag_z);
    end
  endtask

  task automatic test_random();
    int n, wa, wd, lat, ewa, ewd, epc;
    bit we, ewe;
    logic [7:0] ins;
    for (int i = 0; i < 16; i++) begin
      ins = 8'($urandom);
      if (ins[7:4] == 4'h1) ins[7:4] = 4'h3;
      imem[i] = ins;
    end
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_z = 0; m_n = 0; m_c = 0; m_pc = 0;
    ack_wait = $urandom_range(0, 2);
    do_reset();
    for (int k = 0; k < 40; k++) begin
      epc = m_pc;
      model_step(imem[m_pc], lat, ewe, ewa, ewd);
      wait_retire(20, n, we, wa, wd);
      total++;
      if (n !== lat + ack_wait || pc !== 4'(epc)) begin
        bad++; $display("FAIL rand_timing: instr %0d (%h) n=%0d pc=%0d want %0d,%0d", k, imem[epc], n, pc, lat + ack_wait, epc);
      end
      total++;
      if (we !== ewe || (ewe && (wa !== ewa || wd !== ewd))) begin
        bad++; $display("FAIL rand_wb: instr %0d (%h) we=%b wa=%0d wd=%h want %b,%0d,%h", k, imem[epc], we, wa, wd, ewe, ewa, ewd);
      end
      total++;
      if (flag_z !== m_z || flag_n !== m_n || flag_c !== m_c) begin
        bad++; $display("FAIL rand_flags: instr %0d (%h) znc=%b%b%b want %b%b%b", k, imem[epc], flag_z, flag_n, flag_c, m_z, m_n, m_c);
      end
      ack_wait = $urandom_range(0, 2);
    end
    ack_wait = 0;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    test_reset();
    test_program();
    test_wait_en();
    test_halt();
    test_pc_wrap();
    test_reset_mid_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised successor of the 8-bit sequenced processor.
- A multi-cycle FSM controls fetch, decode, register read, execute and writeback. It integrates a register file, a flag-producing ALU and a PC.
- Instructions are fetched over a req/ack handshake, so instruction memory may insert wait states.
- Adds a real HLT, flags, CMP without writeback, an execution-enable stall and a retire/writeback observation port.

Parameters:
- DATA_W, 8, datapath and register width.
- REG_AW, 2, register index width; NREG = 2^REG_AW; INSTR_W = 4 + 2*REG_AW.
- PC_W, 16, PC and instruction address width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable; 0 freezes FSM and all state.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  fetch data valid.
- imem_data  in  INSTR_W  instruction word.
- pc  out  PC_W  current PC.
- halted  out  1  HLT executed.
- flag_z/flag_n/flag_c  out  1 each  zero/negative/carry-out (borrow for SUB: c = ~borrow).
- retire  out  1  one-cycle pulse per completed instruction.
- wb_en  out  1  register write this cycle.
- wb_addr  out  REG_AW  write index.
- wb_data  out  DATA_W  write data.

Behaviour:
- Encoding: op = instr[INSTR_W-1:INSTR_W-4]; rd = next REG_AW bits; rs/imm = low REG_AW bits; imm is sign-extended to DATA_W.
- Opcodes:
  - 0 NOP; 1 HLT; 2 LDI rd<-imm; 3 reserved (executes as NOP).
  - 4 ADD, 5 SUB, 6 AND, 8 OR, A XOR: rd <- rd op rs.
  - 7 CMP: rd-rs, flags only.
  - 9 ADDI, B SUBI, C ANDI, D ORI, E XORI: rd <- rd op imm.
  - F CMPI: rd-imm, flags only.
- Reset (rst=0, async): state FETCH, pc=0, all registers 0, flags 0, imem_req=0, halted=0, retire=0, wb_en=0. A reset mid-instruction abandons it; no partial writeback.
- FSM states FETCH, DECODE, READ, EXEC, WB, HALT:
  - FETCH: imem_req=1 with imem_addr=pc held stable until a posedge samples imem_ack=1; the IR latches imem_data, then go to DECODE. imem_req is 0 in every other state. The first FETCH after reset asserts req one cycle after rst deasserts. imem_ack outside FETCH is ignored.
  - DECODE:
    - NOP/reserved: pc+1, retire, go to FETCH.
    - HLT: go to HALT; pc unchanged.
    - LDI: go to WB.
    - Others: go to READ.
  - READ: latch A=R[rd], B=R[rs] or sext(imm); go to EXEC.
  - EXEC: compute in DATA_W+1 bits; latch result and Z, N, C (logic ops clear C); go to WB.
  - WB: wb_en=1 unless CMP/CMPI; register write; pc+1; retire=1; go to FETCH.
  - HALT: terminal; halted=1, imem_req=0; only reset exits.
- Latency with zero-wait ack:
  - ALU ops: 5 cycles.
  - LDI: 3 cycles.
  - NOP: 2 cycles.
  - Each ack wait cycle adds 1.
- Flags change only in EXEC.
- PC wraps from 2^PC_W-1 to 0.
- en=0 holds the state, pc, IR and imem_req level. An ack arriving while en=0 is not consumed; memory must hold ack/data until it is sampled. en has no effect in HALT.
- Register file: NREG x DATA_W, two combinational read ports, one synchronous write port. Writes do not forward (none are needed, since READ follows WB by at least 2 cycles).

Decomposition:
- Package core_pkg holds the opcode constants, the FSM state enum, and a function is_alu_rr/is_alu_imm/writes_rd.
- One sub-module, core_regfile (parameters DATA_W, REG_AW; clk, rst, 2 read ports, 1 write port).
- The ALU stays inline as a combinational case.

Test Plan:
- Reset: drive rst=0 mid-FETCH -> imem_req=0, pc=0, halted=0 immediately. After release, imem_req=1 with imem_addr=0 one cycle later.
- Program 0x25, 0x45 with zero-wait memory (DATA_W=8):
  - r1=0x01 after LDI (retire at cycle 3).
  - ADD gives wb_addr=1, wb_data=0x02, retire 5 cycles later; Z=0, C=0.
- Continue 0x2A, 0x49, 0x75:
  - r2=0xFE.
  - ADD r2,r1 gives wb_data=0x00, Z=1, C=1.
  - CMP r1,r1 gives Z=1, C=1, wb_en stays 0, retire pulses.
- Wait states: hold imem_ack low 3 cycles -> imem_req and imem_addr stay stable; the ADD completes in 8 cycles; an en=0 pulse during EXEC adds exactly 1 cycle.
- HLT 0x10 at address 5 -> halted=1 after DECODE, pc=5; imem_req stays 0 for 20 cycles despite en and ack toggling.
- PC_W=4 with a NOP stream -> imem_addr goes 14, 15, 0, 1; reset asserted in EXEC of an ADD -> no wb_en, registers return to 0.
